// File: rtl/acc_stack.sv
// acc_stack: accumulator with a small LIFO save stack.
//
// The accumulator can be loaded from the bus, cleared, incremented,
// decremented, shifted or rotated. Its value can also be pushed onto and
// popped from a stack of DEPTH entries.
//
// Ports:
//   clk      - single clock; all state changes on the rising edge
//   reset_n  - asynchronous, active-low reset
//   s        - load d_in into the accumulator
//   e        - drive the accumulator onto d_out (zero when low)
//   d_in     - bus data in
//   op       - 0 hold, 1 clear, 2 inc, 3 dec, 4 shl, 5 shr, 6 rol, 7 ror
//   push     - save the accumulator onto the stack
//   pop      - restore the accumulator from the stack top
//   clr_err  - clear the sticky error flag
//   d_out    - bus data out
//   carry    - carry, borrow or shifted-out bit
//   full     - stack holds DEPTH entries
//   empty    - stack holds no entries
//   count    - number of occupied stack entries
//   err      - sticky overflow/underflow flag
module acc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       s,
    input  logic                       e,
    input  logic [WIDTH-1:0]           d_in,
    input  logic [2:0]                 op,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           d_out,
    output logic                       carry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_INC   = 3'd2;
    localparam logic [2:0] OP_DEC   = 3'd3;
    localparam logic [2:0] OP_SHL   = 3'd4;
    localparam logic [2:0] OP_SHR   = 3'd5;
    localparam logic [2:0] OP_ROL   = 3'd6;
    localparam logic [2:0] OP_ROR   = 3'd7;

    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_err;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_swap;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_new_err;
    logic [CW-1:0]    w_count_m1;
    logic [IW-1:0]    w_push_idx;
    logic [IW-1:0]    w_top_idx;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_carry_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_err_nxt;

    // Stack status and transaction decode.
    always_comb begin
        w_full     = (r_count == DEPTH[CW-1:0]);
        w_empty    = (r_count == {CW{1'b0}});
        w_count_m1 = r_count - {{(CW-1){1'b0}}, 1'b1};
        w_push_idx = r_count[IW-1:0];
        w_top_idx  = w_count_m1[IW-1:0];
        // push and pop together on a non-empty stack exchange acc with the top;
        // on an empty stack the pair degrades to a plain push.
        w_swap     = push & pop & ~w_empty;
        w_push_ok  = push & (~pop | w_empty) & ~w_full;
        w_pop_ok   = pop & ~push & ~w_empty;
        w_new_err  = (push & ~pop & w_full) | (pop & ~push & w_empty);
    end

    // Accumulator and carry next-value: stack restore beats load beats op.
    always_comb begin
        // The extra MSB of each result is the wrap-out bit.
        w_inc       = {1'b0, r_acc} + {{WIDTH{1'b0}}, 1'b1};
        w_dec       = {1'b0, r_acc} - {{WIDTH{1'b0}}, 1'b1};
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        if (w_pop_ok || w_swap) begin
            w_acc_nxt = r_stack[w_top_idx];
        end else if (s) begin
            w_acc_nxt = d_in;
        end else begin
            case (op)
                OP_HOLD: begin
                    w_acc_nxt   = r_acc;
                    w_carry_nxt = r_carry;
                end
                OP_CLEAR: begin
                    w_acc_nxt   = {WIDTH{1'b0}};
                    w_carry_nxt = 1'b0;
                end
                OP_INC: begin
                    w_acc_nxt   = w_inc[WIDTH-1:0];
                    w_carry_nxt = w_inc[WIDTH];
                end
                OP_DEC: begin
                    w_acc_nxt   = w_dec[WIDTH-1:0];
                    w_carry_nxt = w_dec[WIDTH];
                end
                OP_SHL: begin
                    w_acc_nxt   = {r_acc[WIDTH-2:0], 1'b0};
                    w_carry_nxt = r_acc[WIDTH-1];
                end
                OP_SHR: begin
                    w_acc_nxt   = {1'b0, r_acc[WIDTH-1:1]};
                    w_carry_nxt = r_acc[0];
                end
                OP_ROL: begin
                    w_acc_nxt   = {r_acc[WIDTH-2:0], r_acc[WIDTH-1]};
                    w_carry_nxt = r_acc[WIDTH-1];
                end
                OP_ROR: begin
                    w_acc_nxt   = {r_acc[0], r_acc[WIDTH-1:1]};
                    w_carry_nxt = r_acc[0];
                end
                default: begin
                    w_acc_nxt   = r_acc;
                    w_carry_nxt = r_carry;
                end
            endcase
        end
    end

    // Occupancy and sticky error next-value.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok) begin
            w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
        end else if (w_pop_ok) begin
            w_count_nxt = w_count_m1;
        end else begin
            w_count_nxt = r_count;
        end
        // A new error wins over a coincident clear.
        if (w_new_err) begin
            w_err_nxt = 1'b1;
        end else if (clr_err) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_count <= {CW{1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Stack storage; entries above count are never read, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_stack[w_push_idx] <= r_acc;
        end else if (w_swap) begin
            r_stack[w_top_idx] <= r_acc;
        end
    end

    // Output drive; the bus reads zero rather than floating when disabled.
    always_comb begin
        d_out = e ? r_acc : {WIDTH{1'b0}};
        carry = r_carry;
        full  = w_full;
        empty = w_empty;
        count = r_count;
        err   = r_err;
    end

endmodule

// File: tb/tb_acc_stack.sv
// Directed self-checking bench for acc_stack (WIDTH=8, DEPTH=4).
module tb_acc_stack;

    logic       clk;
    logic       reset_n;
    logic       s;
    logic       e;
    logic [7:0] d_in;
    logic [2:0] op;
    logic       push;
    logic       pop;
    logic       clr_err;
    logic [7:0] d_out;
    logic       carry;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       err;

    int checks = 0;
    int errors = 0;

    acc_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .e(e), .d_in(d_in), .op(op),
        .push(push), .pop(pop), .clr_err(clr_err), .d_out(d_out),
        .carry(carry), .full(full), .empty(empty), .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        s = 1'b0; d_in = 8'h00; op = 3'd0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; e = 1'b1; idle();
        #3;
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL rst_dout got %h exp 00", d_out); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL rst_carry got %b exp 0", carry); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags got e%b f%b exp e1 f0", empty, full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL rst_hold got %h exp 00", d_out); end
    endtask

    task automatic test_load();
        idle(); s = 1'b1; d_in = 8'hA5; tick();
        idle();
        checks++; if (d_out !== 8'hA5) begin errors++; $display("FAIL load_e1 got %h exp a5", d_out); end
        e = 1'b0; #1;
        checks++; if (d_out !== 8'h00) begin errors++; $display("FAIL load_e0 got %h exp 00", d_out); end
        e = 1'b1; #1;
        op = 3'd0; tick();
        checks++; if (d_out !== 8'hA5) begin errors++; $display("FAIL hold got %h exp a5", d_out); end
    endtask

    task automatic test_ops();
        logic [7:0] ld  [9] = '{8'hFF, 8'h00, 8'h00, 8'h81, 8'h81, 8'h01, 8'h02, 8'h10, 8'h5C};
        logic [2:0] opv [9] = '{3'd2,  3'd3,  3'd3,  3'd6,  3'd4,  3'd5,  3'd7,  3'd3,  3'd1};
        logic [7:0] xa  [9] = '{8'h00, 8'hFF, 8'hFF, 8'h03, 8'h02, 8'h00, 8'h01, 8'h0F, 8'h00};
        logic       xc  [9] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        for (int i = 0; i < 9; i++) begin
            // Entry 1 chains dec from the inc result without reloading.
            if (i != 1) begin
                idle(); s = 1'b1; d_in = ld[i]; op = 3'd2; tick();
            end
            idle(); op = opv[i]; tick();
            idle();
            checks++; if (d_out !== xa[i] || carry !== xc[i]) begin errors++; $display("FAIL op%0d got %h/%b exp %h/%b", i, d_out, carry, xa[i], xc[i]); end
        end
        // A load must not disturb carry: force carry=1 then load.
        idle(); s = 1'b1; d_in = 8'hFF; tick();
        idle(); op = 3'd2; tick();
        idle(); s = 1'b1; d_in = 8'h40; op = 3'd1; tick();
        idle();
        checks++; if (d_out !== 8'h40 || carry !== 1'b1) begin errors++; $display("FAIL load_carry got %h/%b exp 40/1", d_out, carry); end
    endtask

    task automatic test_stack();
        logic [7:0] xp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        idle(); s = 1'b1; d_in = 8'h11; tick();
        push = 1'b1; d_in = 8'h22; tick();
        d_in = 8'h33; tick();
        d_in = 8'h44; tick();
        s = 1'b0; tick();
        idle();
        checks++; if (full !== 1'b1 || count !== 3'd4 || err !== 1'b0) begin errors++; $display("FAIL fill got f%b c%0d e%b exp f1 c4 e0", full, count, err); end
        push = 1'b1; op = 3'd2; tick();
        idle();
        checks++; if (err !== 1'b1 || count !== 3'd4 || d_out !== 8'h45) begin errors++; $display("FAIL overflow got e%b c%0d %h exp e1 c4 45", err, count, d_out); end
        push = 1'b1; clr_err = 1'b1; tick();
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_vs_err got %b exp 1", err); end
        clr_err = 1'b1; tick();
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clr_err got %b exp 0", err); end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; s = 1'b1; d_in = 8'hEE; op = 3'd1; tick();
            idle();
            checks++; if (d_out !== xp[i] || count !== 3'(3 - i)) begin errors++; $display("FAIL pop%0d got %h c%0d exp %h c%0d", i, d_out, count, xp[i], 3 - i); end
        end
        checks++; if (empty !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL drained got e%b err%b exp e1 err0", empty, err); end
    endtask

    task automatic test_pop_empty();
        idle(); pop = 1'b1; s = 1'b1; d_in = 8'h5A; tick();
        idle();
        checks++; if (err !== 1'b1 || d_out !== 8'h5A || count !== 3'd0) begin errors++; $display("FAIL underflow got e%b %h c%0d exp e1 5a c0", err, d_out, count); end
        clr_err = 1'b1; tick();
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL uf_clr got %b exp 0", err); end
    endtask

    task automatic test_swap();
        idle(); s = 1'b1; d_in = 8'h10; tick();
        push = 1'b1; d_in = 8'h77; tick();
        idle(); push = 1'b1; pop = 1'b1; s = 1'b1; d_in = 8'hCC; tick();
        idle();
        checks++; if (d_out !== 8'h10 || count !== 3'd1 || err !== 1'b0) begin errors++; $display("FAIL swap got %h c%0d e%b exp 10 c1 e0", d_out, count, err); end
        pop = 1'b1; tick();
        idle();
        checks++; if (d_out !== 8'h77 || count !== 3'd0) begin errors++; $display("FAIL swap_top got %h c%0d exp 77 c0", d_out, count); end
        push = 1'b1; pop = 1'b1; tick();
        idle();
        checks++; if (count !== 3'd1 || err !== 1'b0 || d_out !== 8'h77) begin errors++; $display("FAIL swap_empty got c%0d e%b %h exp c1 e0 77", count, err, d_out); end
        push = 1'b1; s = 1'b1; d_in = 8'h99; tick();
        idle();
        checks++; if (d_out !== 8'h99 || count !== 3'd2) begin errors++; $display("FAIL push_load got %h c%0d exp 99 c2", d_out, count); end
        pop = 1'b1; tick();
        idle();
        checks++; if (d_out !== 8'h77 || count !== 3'd1) begin errors++; $display("FAIL push_saved got %h c%0d exp 77 c1", d_out, count); end
        pop = 1'b1; tick();
        idle();
    endtask

    task automatic test_async_reset();
        idle(); pop = 1'b1; tick();
        idle(); push = 1'b1; s = 1'b1; d_in = 8'h21; tick();
        tick();
        idle();
        checks++; if (count !== 3'd2 || err !== 1'b1) begin errors++; $display("FAIL pre_arst got c%0d e%b exp c2 e1", count, err); end
        e = 1'b1; push = 1'b1; s = 1'b1; d_in = 8'h3C;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || err !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL arst_state got c%0d e%b em%b f%b exp c0 e0 em1 f0", count, err, empty, full); end
        checks++; if (d_out !== 8'h00 || carry !== 1'b0) begin errors++; $display("FAIL arst_acc got %h/%b exp 00/0", d_out, carry); end
        #1 reset_n = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || d_out !== 8'h00) begin errors++; $display("FAIL arst_rel got c%0d %h exp c0 00", count, d_out); end
        tick();
        idle();
        checks++; if (count !== 3'd1 || d_out !== 8'h3C || err !== 1'b0) begin errors++; $display("FAIL arst_first got c%0d %h e%b exp c1 3c e0", count, d_out, err); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_ops();
        test_stack();
        test_pop_empty();
        test_swap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
